// File: rtl/axi_lrsc_write_arbiter.sv
// ----------------------------------------------------------------------------
// axi_lrsc_write_arbiter
//
// Purpose:
//   Shares one AXI write path (AW, W, B) among NUM_REQ requesters that feed
//   the slave port of an LR/SC adapter.
//   - AW is arbitrated round-robin. A grant that has not been accepted
//     downstream is held until it completes.
//   - W beats follow AW-grant order, tracked by an internal order FIFO.
//   - B responses are routed by a requester-index prefix that is prepended
//     to the AW ID, so the adapter sees a unique ID per requester.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   slv_aw_* / slv_w_*    per-requester AW/W channels, requester r in slice r
//   slv_b_*               per-requester B channels (prefix stripped from ID)
//   mst_aw_* / mst_w_*    single arbitrated AW/W channel towards the adapter
//   mst_b_*               single B channel from the adapter
// ----------------------------------------------------------------------------
module axi_lrsc_write_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MAX_W_TXNS     = 8,
    localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int STRB_W        = AXI_DATA_WIDTH / 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,

    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   slv_aw_addr_i,
    input  logic [NUM_REQ*AXI_ID_WIDTH-1:0]     slv_aw_id_i,
    input  logic [NUM_REQ*8-1:0]                slv_aw_len_i,
    input  logic [NUM_REQ*3-1:0]                slv_aw_size_i,
    input  logic [NUM_REQ-1:0]                  slv_aw_lock_i,
    input  logic [NUM_REQ*6-1:0]                slv_aw_atop_i,
    input  logic [NUM_REQ-1:0]                  slv_aw_valid_i,
    output logic [NUM_REQ-1:0]                  slv_aw_ready_o,

    input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   slv_w_data_i,
    input  logic [NUM_REQ*STRB_W-1:0]           slv_w_strb_i,
    input  logic [NUM_REQ-1:0]                  slv_w_last_i,
    input  logic [NUM_REQ-1:0]                  slv_w_valid_i,
    output logic [NUM_REQ-1:0]                  slv_w_ready_o,

    output logic [NUM_REQ*AXI_ID_WIDTH-1:0]     slv_b_id_o,
    output logic [NUM_REQ*2-1:0]                slv_b_resp_o,
    output logic [NUM_REQ-1:0]                  slv_b_valid_o,
    input  logic [NUM_REQ-1:0]                  slv_b_ready_i,

    output logic [AXI_ADDR_WIDTH-1:0]           mst_aw_addr_o,
    output logic [IDX_W+AXI_ID_WIDTH-1:0]       mst_aw_id_o,
    output logic [7:0]                          mst_aw_len_o,
    output logic [2:0]                          mst_aw_size_o,
    output logic                                mst_aw_lock_o,
    output logic [5:0]                          mst_aw_atop_o,
    output logic                                mst_aw_valid_o,
    input  logic                                mst_aw_ready_i,

    output logic [AXI_DATA_WIDTH-1:0]           mst_w_data_o,
    output logic [STRB_W-1:0]                   mst_w_strb_o,
    output logic                                mst_w_last_o,
    output logic                                mst_w_valid_o,
    input  logic                                mst_w_ready_i,

    input  logic [IDX_W+AXI_ID_WIDTH-1:0]       mst_b_id_i,
    input  logic [1:0]                          mst_b_resp_i,
    input  logic                                mst_b_valid_i,
    output logic                                mst_b_ready_o
);

    localparam int PTR_W = (MAX_W_TXNS > 1) ? $clog2(MAX_W_TXNS) : 1;
    localparam int CNT_W = $clog2(MAX_W_TXNS + 1);

    typedef enum logic {
        AW_IDLE,
        AW_HOLD
    } aw_state_e;

    aw_state_e              aw_state_q, aw_state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [IDX_W-1:0]       fifo_q [MAX_W_TXNS];
    logic [IDX_W-1:0]       fifo_d [MAX_W_TXNS];

    logic                   found;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       aw_sel;
    logic                   aw_valid;
    logic                   aw_hs;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [IDX_W-1:0]       head_idx;
    logic                   w_valid;
    logic                   w_last;
    logic                   w_pop;
    logic [IDX_W-1:0]       b_idx;

    assign fifo_full  = (count_q == CNT_W'(MAX_W_TXNS));
    assign fifo_empty = (count_q == '0);
    assign head_idx   = fifo_q[rd_ptr_q];
    assign b_idx      = mst_b_id_i[IDX_W+AXI_ID_WIDTH-1 -: IDX_W];

    // Round-robin search: first valid at or above rr_ptr, otherwise the
    // first valid from 0, which is the wrap-around part of the search.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (!found && slv_aw_valid_i[r] && (r >= int'(rr_ptr_q))) begin
                found  = 1'b1;
                winner = IDX_W'(r);
            end
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (!found && slv_aw_valid_i[r]) begin
                found  = 1'b1;
                winner = IDX_W'(r);
            end
        end
    end

    // AW FSM. In HOLD the latched grant is driven regardless of the other
    // valids because an AXI master may not withdraw a raised valid.
    always_comb begin
        aw_state_d = aw_state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        aw_sel     = winner;
        aw_valid   = 1'b0;

        if (aw_state_q == AW_HOLD) begin
            aw_sel   = grant_q;
            aw_valid = 1'b1;
        end else begin
            aw_valid = found && !fifo_full;
        end

        aw_hs = aw_valid && mst_aw_ready_i;

        case (aw_state_q)
            AW_IDLE: begin
                if (aw_valid && !aw_hs) begin
                    grant_d    = winner;
                    aw_state_d = AW_HOLD;
                end
            end
            AW_HOLD: begin
                if (aw_hs) begin
                    aw_state_d = AW_IDLE;
                end
            end
            default: aw_state_d = AW_IDLE;
        endcase

        if (aw_hs) begin
            rr_ptr_d = (aw_sel == IDX_W'(NUM_REQ - 1)) ? '0 : aw_sel + 1'b1;
        end
    end

    // AW field multiplexing and per-requester ready.
    always_comb begin
        mst_aw_addr_o  = '0;
        mst_aw_id_o    = '0;
        mst_aw_len_o   = '0;
        mst_aw_size_o  = '0;
        mst_aw_lock_o  = 1'b0;
        mst_aw_atop_o  = '0;
        slv_aw_ready_o = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (aw_sel == IDX_W'(r)) begin
                mst_aw_addr_o     = slv_aw_addr_i[r*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                mst_aw_id_o       = {aw_sel, slv_aw_id_i[r*AXI_ID_WIDTH +: AXI_ID_WIDTH]};
                mst_aw_len_o      = slv_aw_len_i[r*8 +: 8];
                mst_aw_size_o     = slv_aw_size_i[r*3 +: 3];
                mst_aw_lock_o     = slv_aw_lock_i[r];
                mst_aw_atop_o     = slv_aw_atop_i[r*6 +: 6];
                slv_aw_ready_o[r] = aw_valid && mst_aw_ready_i && !rst_i;
            end
        end
        mst_aw_valid_o = aw_valid && !rst_i;
    end

    // W routing from the FIFO head. The FIFO is only written at the clock
    // edge, so a burst's W beats cannot pass in its own AW handshake cycle.
    always_comb begin
        mst_w_data_o  = '0;
        mst_w_strb_o  = '0;
        w_last        = 1'b0;
        w_valid       = 1'b0;
        slv_w_ready_o = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (head_idx == IDX_W'(r)) begin
                mst_w_data_o     = slv_w_data_i[r*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                mst_w_strb_o     = slv_w_strb_i[r*STRB_W +: STRB_W];
                w_last           = slv_w_last_i[r];
                w_valid          = slv_w_valid_i[r] && !fifo_empty;
                slv_w_ready_o[r] = mst_w_ready_i && !fifo_empty && !rst_i;
            end
        end
        mst_w_last_o  = w_last;
        mst_w_valid_o = w_valid && !rst_i;
        w_pop         = w_valid && mst_w_ready_i && w_last;
    end

    // Order FIFO: push on AW handshake, pop on the last W beat.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (aw_hs) begin
            fifo_d[wr_ptr_q] = aw_sel;
            wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_W_TXNS - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_W_TXNS - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(aw_hs) - CNT_W'(w_pop);
    end

    // B routing by ID prefix; the response fields are broadcast and only the
    // addressed requester sees valid.
    always_comb begin
        slv_b_id_o    = '0;
        slv_b_resp_o  = '0;
        slv_b_valid_o = '0;
        mst_b_ready_o = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            slv_b_id_o[r*AXI_ID_WIDTH +: AXI_ID_WIDTH] = mst_b_id_i[AXI_ID_WIDTH-1:0];
            slv_b_resp_o[r*2 +: 2] = mst_b_resp_i;
            if (b_idx == IDX_W'(r)) begin
                slv_b_valid_o[r] = mst_b_valid_i && !rst_i;
                mst_b_ready_o    = slv_b_ready_i[r] && !rst_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_state_q <= AW_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            aw_state_q <= aw_state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q > 0.
    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end

    // A response prefix that names no requester means the adapter corrupted the ID.
    a_b_prefix_in_range: assert property (
        @(posedge clk_i) disable iff (rst_i)
        mst_b_valid_i |-> (32'(b_idx) < NUM_REQ)
    );

endmodule

// File: tb/tb_axi_lrsc_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_lrsc_write_arbiter
//
// Table-driven bench for axi_lrsc_write_arbiter (4 requesters, order FIFO
// depth 3, narrow 16-bit address/data). Inputs change on the falling edge
// and outputs are compared 1 ns later, before the next rising edge.
// Requester r uses AW id 8+r, address 0x1000+0x100*r and W data 0xC000+r,
// so the expected prefixed ID of requester r is (r<<4)|(8+r).
// ----------------------------------------------------------------------------
module tb_axi_lrsc_write_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int IW  = 4;
    localparam int IDX = 2;
    localparam int SW  = DW / 8;

    logic                clk_i;
    logic                rst_i;
    logic [NR*AW-1:0]    slv_aw_addr;
    logic [NR*IW-1:0]    slv_aw_id;
    logic [NR*8-1:0]     slv_aw_len;
    logic [NR*3-1:0]     slv_aw_size;
    logic [NR-1:0]       slv_aw_lock;
    logic [NR*6-1:0]     slv_aw_atop;
    logic [NR-1:0]       slv_aw_valid;
    logic [NR-1:0]       slv_aw_ready;
    logic [NR*DW-1:0]    slv_w_data;
    logic [NR*SW-1:0]    slv_w_strb;
    logic [NR-1:0]       slv_w_last;
    logic [NR-1:0]       slv_w_valid;
    logic [NR-1:0]       slv_w_ready;
    logic [NR*IW-1:0]    slv_b_id;
    logic [NR*2-1:0]     slv_b_resp;
    logic [NR-1:0]       slv_b_valid;
    logic [NR-1:0]       slv_b_ready;
    logic [AW-1:0]       mst_aw_addr;
    logic [IDX+IW-1:0]   mst_aw_id;
    logic [7:0]          mst_aw_len;
    logic [2:0]          mst_aw_size;
    logic                mst_aw_lock;
    logic [5:0]          mst_aw_atop;
    logic                mst_aw_valid;
    logic                mst_aw_ready;
    logic [DW-1:0]       mst_w_data;
    logic [SW-1:0]       mst_w_strb;
    logic                mst_w_last;
    logic                mst_w_valid;
    logic                mst_w_ready;
    logic [IDX+IW-1:0]   mst_b_id;
    logic [1:0]          mst_b_resp;
    logic                mst_b_valid;
    logic                mst_b_ready;

    int n_checks = 0;
    int n_pass   = 0;

    axi_lrsc_write_arbiter #(
        .NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
        .AXI_ID_WIDTH(IW), .MAX_W_TXNS(3)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .slv_aw_addr_i(slv_aw_addr), .slv_aw_id_i(slv_aw_id), .slv_aw_len_i(slv_aw_len),
        .slv_aw_size_i(slv_aw_size), .slv_aw_lock_i(slv_aw_lock), .slv_aw_atop_i(slv_aw_atop),
        .slv_aw_valid_i(slv_aw_valid), .slv_aw_ready_o(slv_aw_ready),
        .slv_w_data_i(slv_w_data), .slv_w_strb_i(slv_w_strb), .slv_w_last_i(slv_w_last),
        .slv_w_valid_i(slv_w_valid), .slv_w_ready_o(slv_w_ready),
        .slv_b_id_o(slv_b_id), .slv_b_resp_o(slv_b_resp), .slv_b_valid_o(slv_b_valid),
        .slv_b_ready_i(slv_b_ready),
        .mst_aw_addr_o(mst_aw_addr), .mst_aw_id_o(mst_aw_id), .mst_aw_len_o(mst_aw_len),
        .mst_aw_size_o(mst_aw_size), .mst_aw_lock_o(mst_aw_lock), .mst_aw_atop_o(mst_aw_atop),
        .mst_aw_valid_o(mst_aw_valid), .mst_aw_ready_i(mst_aw_ready),
        .mst_w_data_o(mst_w_data), .mst_w_strb_o(mst_w_strb), .mst_w_last_o(mst_w_last),
        .mst_w_valid_o(mst_w_valid), .mst_w_ready_i(mst_w_ready),
        .mst_b_id_i(mst_b_id), .mst_b_resp_i(mst_b_resp), .mst_b_valid_i(mst_b_valid),
        .mst_b_ready_o(mst_b_ready)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  aw_valid;
        logic        aw_ready;
        logic [3:0]  w_valid;
        logic        w_ready;
        logic        exp_aw_valid;
        logic [5:0]  exp_aw_id;
        logic [3:0]  exp_aw_rdy;
        logic        exp_w_valid;
        logic [15:0] exp_w_data;
        logic [3:0]  exp_w_rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] awv, logic awr, logic [3:0] wv, logic wr,
                                logic eav, logic [5:0] eid, logic [3:0] eardy,
                                logic ewv, logic [15:0] ewd, logic [3:0] ewrdy);
        vec_t v;
        v.aw_valid = awv;  v.aw_ready = awr;  v.w_valid = wv;  v.w_ready = wr;
        v.exp_aw_valid = eav;  v.exp_aw_id = eid;  v.exp_aw_rdy = eardy;
        v.exp_w_valid = ewv;  v.exp_w_data = ewd;  v.exp_w_rdy = ewrdy;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        slv_aw_valid = v.aw_valid;
        mst_aw_ready = v.aw_ready;
        slv_w_valid  = v.w_valid;
        mst_w_ready  = v.w_ready;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic checkVector(input int i, input vec_t v);
        checkOutput($sformatf("v%0d mst_aw_valid", i), 64'(mst_aw_valid), 64'(v.exp_aw_valid));
        if (v.exp_aw_valid)
            checkOutput($sformatf("v%0d mst_aw_id", i), 64'(mst_aw_id), 64'(v.exp_aw_id));
        checkOutput($sformatf("v%0d slv_aw_ready", i), 64'(slv_aw_ready), 64'(v.exp_aw_rdy));
        checkOutput($sformatf("v%0d mst_w_valid", i), 64'(mst_w_valid), 64'(v.exp_w_valid));
        if (v.exp_w_valid)
            checkOutput($sformatf("v%0d mst_w_data", i), 64'(mst_w_data), 64'(v.exp_w_data));
        checkOutput($sformatf("v%0d slv_w_ready", i), 64'(slv_w_ready), 64'(v.exp_w_rdy));
    endtask

    task automatic checkAllIdle(input string tag);
        checkOutput({tag, " mst_aw_valid"}, 64'(mst_aw_valid), 64'(0));
        checkOutput({tag, " slv_aw_ready"}, 64'(slv_aw_ready), 64'(0));
        checkOutput({tag, " mst_w_valid"},  64'(mst_w_valid),  64'(0));
        checkOutput({tag, " slv_w_ready"},  64'(slv_w_ready),  64'(0));
        checkOutput({tag, " slv_b_valid"},  64'(slv_b_valid),  64'(0));
        checkOutput({tag, " mst_b_ready"},  64'(mst_b_ready),  64'(0));
    endtask

    task automatic driveAllActive();
        slv_aw_valid = 4'b1111;  mst_aw_ready = 1'b1;
        slv_w_valid  = 4'b1111;  mst_w_ready  = 1'b1;
        mst_b_valid  = 1'b1;     mst_b_id     = 6'b01_0001;
        slv_b_ready  = 4'b1111;
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin
            slv_aw_addr[r*AW +: AW] = 16'h1000 + 16'(r) * 16'h0100;
            slv_aw_id[r*IW +: IW]   = 4'(8 + r);
            slv_aw_len[r*8 +: 8]    = 8'd0;
            slv_aw_size[r*3 +: 3]   = 3'd1;
            slv_aw_atop[r*6 +: 6]   = 6'd0;
            slv_w_data[r*DW +: DW]  = 16'hC000 | 16'(r);
            slv_w_strb[r*SW +: SW]  = '1;
        end
        slv_aw_lock = 4'b0100;
        slv_w_last  = 4'b1111;
        mst_b_resp  = 2'b00;

        // Round robin with all requesters active, W draining in grant order.
        vecs.push_back(mk(4'b1111,1,4'b1111,1, 1,6'h08,4'b0001, 0,16'h0000,4'b0000));
        vecs.push_back(mk(4'b1111,1,4'b1111,1, 1,6'h19,4'b0010, 1,16'hC000,4'b0001));
        vecs.push_back(mk(4'b1111,1,4'b1111,1, 1,6'h2A,4'b0100, 1,16'hC001,4'b0010));
        vecs.push_back(mk(4'b1111,1,4'b1111,1, 1,6'h3B,4'b1000, 1,16'hC002,4'b0100));
        vecs.push_back(mk(4'b1111,1,4'b1111,1, 1,6'h08,4'b0001, 1,16'hC003,4'b1000));
        vecs.push_back(mk(4'b0000,1,4'b1111,1, 0,6'h00,4'b0000, 1,16'hC000,4'b0001));
        vecs.push_back(mk(4'b0000,1,4'b1111,1, 0,6'h00,4'b0000, 0,16'h0000,4'b0000));
        // Req2 held while the downstream stalls, req0 joins, then granted after.
        vecs.push_back(mk(4'b0100,0,4'b0000,1, 1,6'h2A,4'b0000, 0,16'h0000,4'b0000));
        vecs.push_back(mk(4'b0101,0,4'b0000,1, 1,6'h2A,4'b0000, 0,16'h0000,4'b0000));
        vecs.push_back(mk(4'b0101,0,4'b0000,1, 1,6'h2A,4'b0000, 0,16'h0000,4'b0000));
        vecs.push_back(mk(4'b0101,1,4'b0000,1, 1,6'h2A,4'b0100, 0,16'h0000,4'b0000));
        vecs.push_back(mk(4'b0001,1,4'b0000,1, 1,6'h08,4'b0001, 0,16'h0000,4'b0100));
        // Third grant fills the order FIFO; req3 waits until one burst completes.
        vecs.push_back(mk(4'b0010,1,4'b0000,1, 1,6'h19,4'b0010, 0,16'h0000,4'b0100));
        vecs.push_back(mk(4'b1000,1,4'b0000,1, 0,6'h00,4'b0000, 0,16'h0000,4'b0100));
        vecs.push_back(mk(4'b1000,1,4'b0100,1, 0,6'h00,4'b0000, 1,16'hC002,4'b0100));
        vecs.push_back(mk(4'b1000,1,4'b0000,1, 1,6'h3B,4'b1000, 0,16'h0000,4'b0001));
        vecs.push_back(mk(4'b0000,1,4'b0001,1, 0,6'h00,4'b0000, 1,16'hC000,4'b0001));
        vecs.push_back(mk(4'b0000,1,4'b0010,1, 0,6'h00,4'b0000, 1,16'hC001,4'b0010));
        vecs.push_back(mk(4'b0000,1,4'b1000,1, 0,6'h00,4'b0000, 1,16'hC003,4'b1000));
        vecs.push_back(mk(4'b0000,0,4'b0000,0, 0,6'h00,4'b0000, 0,16'h0000,4'b0000));

        // Reset with every input active: all valids and readys must stay low.
        rst_i = 1'b1;
        driveAllActive();
        @(negedge clk_i);
        #1;
        checkAllIdle("reset");
        @(negedge clk_i);
        rst_i       = 1'b0;
        mst_b_valid = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkVector(i, vecs[i]);
            @(negedge clk_i);
        end

        // Four-beat burst from req1 blocks req3's early single beat.
        $display("[TB] W ordering across a 4-beat burst");
        slv_aw_len[1*8 +: 8] = 8'd3;
        slv_w_last = 4'b1101;
        applyStimulus(mk(4'b0010,1,4'b1000,1, 0,0,0,0,0,0));
        #1;
        checkOutput("burst aw_id req1", 64'(mst_aw_id), 64'(6'h19));
        checkOutput("burst aw_len req1", 64'(mst_aw_len), 64'(3));
        checkOutput("burst aw_addr req1", 64'(mst_aw_addr), 64'(16'h1100));
        checkOutput("burst aw_lock req1", 64'(mst_aw_lock), 64'(0));
        checkOutput("burst w_valid empty", 64'(mst_w_valid), 64'(0));
        @(negedge clk_i);
        applyStimulus(mk(4'b1000,1,4'b1000,1, 0,0,0,0,0,0));
        #1;
        checkOutput("burst aw_id req3", 64'(mst_aw_id), 64'(6'h3B));
        checkOutput("burst aw_len req3", 64'(mst_aw_len), 64'(0));
        checkOutput("burst req3 stalled valid", 64'(mst_w_valid), 64'(0));
        checkOutput("burst req3 stalled ready", 64'(slv_w_ready), 64'(4'b0010));
        @(negedge clk_i);
        for (int b = 0; b < 4; b++) begin
            slv_w_last = (b == 3) ? 4'b1111 : 4'b1101;
            applyStimulus(mk(4'b0000,1,4'b1010,1, 0,0,0,0,0,0));
            #1;
            checkOutput($sformatf("burst beat%0d valid", b), 64'(mst_w_valid), 64'(1));
            checkOutput($sformatf("burst beat%0d data", b), 64'(mst_w_data), 64'(16'hC001));
            checkOutput($sformatf("burst beat%0d last", b), 64'(mst_w_last), 64'(b == 3));
            checkOutput($sformatf("burst beat%0d ready", b), 64'(slv_w_ready), 64'(4'b0010));
            @(negedge clk_i);
        end
        applyStimulus(mk(4'b0000,1,4'b1000,1, 0,0,0,0,0,0));
        #1;
        checkOutput("burst req3 data", 64'(mst_w_data), 64'(16'hC003));
        checkOutput("burst req3 ready", 64'(slv_w_ready), 64'(4'b1000));
        @(negedge clk_i);
        applyStimulus(mk(4'b0000,1,4'b0000,1, 0,0,0,0,0,0));
        #1;
        checkOutput("burst drained", 64'(mst_w_valid), 64'(0));
        slv_aw_len[1*8 +: 8] = 8'd0;

        // B routing: prefix 2 with backpressure, then prefix 0.
        $display("[TB] B routing");
        mst_b_id    = 6'b10_0101;
        mst_b_resp  = 2'b01;
        mst_b_valid = 1'b1;
        slv_b_ready = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) slv_b_ready = 4'b1111;
            #1;
            checkOutput($sformatf("b%0d slv_b_valid", c), 64'(slv_b_valid), 64'(4'b0100));
            checkOutput($sformatf("b%0d slv_b_id[2]", c), 64'(slv_b_id[2*IW +: IW]), 64'(4'b0101));
            checkOutput($sformatf("b%0d slv_b_resp[2]", c), 64'(slv_b_resp[2*2 +: 2]), 64'(2'b01));
            checkOutput($sformatf("b%0d mst_b_ready", c), 64'(mst_b_ready), 64'(c == 2));
            @(negedge clk_i);
        end
        mst_b_id   = 6'b00_0011;
        mst_b_resp = 2'b00;
        #1;
        checkOutput("b req0 valid", 64'(slv_b_valid), 64'(4'b0001));
        checkOutput("b req0 id", 64'(slv_b_id[0 +: IW]), 64'(4'b0011));
        checkOutput("b req0 ready", 64'(mst_b_ready), 64'(1));
        @(negedge clk_i);
        mst_b_valid = 1'b0;

        // Reset while two bursts are queued and the FSM is holding req2.
        $display("[TB] reset during HOLD");
        applyStimulus(mk(4'b0001,1,4'b0000,1, 0,0,0,0,0,0));
        @(negedge clk_i);
        applyStimulus(mk(4'b0010,1,4'b0000,1, 0,0,0,0,0,0));
        @(negedge clk_i);
        applyStimulus(mk(4'b0100,0,4'b0000,1, 0,0,0,0,0,0));
        #1;
        checkOutput("hold setup aw_id", 64'(mst_aw_id), 64'(6'h2A));
        @(negedge clk_i);
        rst_i = 1'b1;
        driveAllActive();
        #1;
        checkAllIdle("mid-hold reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        mst_b_valid = 1'b0;
        applyStimulus(mk(4'b1111,0,4'b1111,1, 0,0,0,0,0,0));
        #1;
        checkOutput("post-reset aw_valid", 64'(mst_aw_valid), 64'(1));
        checkOutput("post-reset rr start", 64'(mst_aw_id), 64'(6'h08));
        checkOutput("post-reset w_valid", 64'(mst_w_valid), 64'(0));
        checkOutput("post-reset w_ready", 64'(slv_w_ready), 64'(0));
        @(negedge clk_i);
        applyStimulus(mk(4'b0001,1,4'b1111,1, 0,0,0,0,0,0));
        #1;
        checkOutput("post-reset aw_ready", 64'(slv_aw_ready), 64'(4'b0001));
        @(negedge clk_i);
        applyStimulus(mk(4'b0000,1,4'b1111,1, 0,0,0,0,0,0));
        #1;
        checkOutput("post-reset w head", 64'(mst_w_data), 64'(16'hC000));
        checkOutput("post-reset w ready", 64'(slv_w_ready), 64'(4'b0001));
        @(negedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
